if_fetch_sequencer: RTL
=======================

# if_fetch_sequencer

Fetch-side initiator for the IF stage: owns the program counter, issues word requests to the synchronous instruction memory, and captures returned words into the IF/ID register along with their PC and next PC. Handles pipeline stall (with a one-entry skid buffer for in-flight data), branch redirect with flush, and an optional end-of-program halt. Sits between the branch/hazard logic and the instruction memory.

## Interface
- RESET_PC, 32'd0, byte address of the first fetch after reset
- HALT_ADDR, 32'd48, byte address whose fetch ends the program (used only with IF_HALT_EN)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- stall  in  1  hazard stall; holds PC and IF/ID outputs
- branch_taken  in  1  redirect request, sampled at the clock edge
- branch_target  in  32  redirect byte address
- imem_req  out  1  fetch request (combinational from state/pc)
- imem_addr  out  32  fetch byte address (word index = imem_addr[31:2])
- imem_rdata  in  32  memory word; valid the cycle after a sampled request
- if_instr  out  32  IF/ID instruction
- if_pc  out  32  address of if_instr
- if_nextpc  out  32  if_pc + 4
- if_valid  out  1  IF/ID holds a real instruction
- halted  out  1  fetch permanently stopped

## Operation
- States: IDLE, RUN, HOLD, HALTED. Reset -> IDLE.
- IDLE: no request; the first edge moves to RUN (or HOLD if stall = 1).
- RUN: imem_req = 1, imem_addr = pc; at each edge pc <= pc + 4 and the in-flight tag records the requested address. stall = 1 -> HOLD.
- HOLD: imem_req = 0; pc, if_* held. A response returning during the first HOLD cycle is written into the skid buffer (word + pc). stall = 0 -> RUN; on that edge IF/ID loads the skid entry if valid; otherwise it loads the in-flight response.
- Response capture: in RUN, IF/ID loads {imem_rdata, tag, tag + 4} and sets if_valid = 1 one edge after the request edge; if no response is in flight, if_valid <= 0.
- Branch (highest priority, any state except IDLE): pc <= {branch_target[31:2], 2'b00}; in-flight response killed; skid cleared; if_valid <= 0. The state is otherwise unchanged (HOLD stays HOLD), except HALTED -> RUN.
- Arithmetic: pc is 32-bit, increments by 4 with natural 2^32 wrap; misaligned targets are silently forced to word alignment.

## Timing
- Reset values: imem_req 0, imem_addr RESET_PC, if_instr 0, if_pc 0, if_nextpc 0, if_valid 0, halted 0, skid empty, pc RESET_PC.
- Latency: request in cycle N -> if_valid/if_instr in cycle N+2; throughput is one instruction per cycle in RUN.
- Branch at edge E: the first target request occurs in cycle E+1; target instruction in IF/ID in cycle E+3; exactly two bubbles.
- stall rising edge: at most one response lands in the skid; no words are lost or duplicated across any stall length.
- Simultaneous stall + branch: branch wins for pc/flush; IF/ID becomes invalid even though stalled.
- Reset mid-operation: all state is cleared immediately (async); the in-flight response after reset deassertion is ignored.

## Configuration
- IF_HALT_EN defined: in RUN, when pc == HALT_ADDR, no request is issued, the state -> HALTED, and halted = 1 from the next edge; the last in-flight word is still captured. HALTED holds if_* with if_valid <= 0 after the drain; only a branch or reset exits.
- Undefined: HALTED is unreachable; halted is tied to 0; HALT_ADDR is ignored.

## Structure
- Shared package if_pkg: state enum (IDLE/RUN/HOLD/HALTED), NOP word constant 32'd0, PC_STEP 32'd4, default RESET_PC.
- One sub-module: if_skid_buffer (1-entry, word + pc, load/clear/valid).

## Test plan
- Reset release, no stall, memory words at 0..12 -> if_pc = 0, 4, 8, 12 in consecutive cycles, first if_valid 2 cycles after the first request.
- 3-cycle stall asserted while 0x8 is in flight -> 0x8 appears exactly once after release, followed by 0xC; no gaps, no repeats.
- branch_taken with target 0x20 while streaming at 0x10 -> two invalid cycles, then if_pc = 0x20; the word from 0x14 is never valid.
- Branch with target 0x23 during stall -> pc = 0x20, if_valid = 0 immediately, and fetch at 0x20 resumes after stall drops.
- With IF_HALT_EN and HALT_ADDR = 48 -> last valid if_pc = 44, halted = 1, no request to 48; a subsequent branch to 0 restarts fetch.
- Async reset asserted mid-stream -> all outputs return to their reset values without waiting for a clock edge.

Source files
------------

// File: rtl/if_pkg.sv
// ---------------------------------------------------------------------------
// if_pkg
// Shared definitions for the instruction-fetch sequencer and its skid buffer:
// fetch state encoding, the NOP word, the PC increment, the default reset PC
// and a helper that forces a byte address onto a word boundary.
// ---------------------------------------------------------------------------
package if_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HOLD   = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_WORD         = 32'd0;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'd0;

    // Misaligned redirect targets are silently pulled down to the word.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/if_skid_buffer.sv
// ---------------------------------------------------------------------------
// if_skid_buffer
// One-entry holding register for a fetch response that returns while the
// IF stage is stalled. Stores the instruction word and the PC it came from.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous, active-high
//   load     in   capture word_in/pc_in and mark the entry valid
//   clear    in   drop the entry (wins over load)
//   word_in  in   [31:0] instruction word to store
//   pc_in    in   [31:0] byte address of word_in
//   valid    out  entry holds a word
//   word     out  [31:0] stored instruction word
//   pc       out  [31:0] stored byte address
// ---------------------------------------------------------------------------
module if_skid_buffer
    import if_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] word_in,
    input  logic [31:0] pc_in,
    output logic        valid,
    output logic [31:0] word,
    output logic [31:0] pc
);

    // NOTE: state is written with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            // NOTE: the payload is reset along with valid so an empty entry
            // never exposes X to the IF/ID mux in simulation.
            word  <= NOP_WORD;
            pc    <= 32'd0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            word  <= word_in;
            pc    <= pc_in;
        end
    end

endmodule

// File: rtl/if_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// if_fetch_sequencer
// IF-stage fetch initiator. Owns the PC, issues word requests to a
// synchronous instruction memory (data returns the cycle after a sampled
// request) and writes returned words into the IF/ID register together with
// their PC and next PC. Handles hazard stall through a one-entry skid
// buffer, branch redirect with flush, and an optional end-of-program halt.
//
// Build option:
//   IF_HALT_EN  when defined, reaching HALT_ADDR in RUN stops fetch for good
//               (until a branch or reset). Undefined: halted is tied to 0.
//
// Parameters:
//   RESET_PC   byte address of the first fetch after reset
//   HALT_ADDR  byte address whose fetch ends the program (IF_HALT_EN only)
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   asynchronous, active-high
//   stall          in   hazard stall; holds PC and IF/ID outputs
//   branch_taken   in   redirect request, sampled at the clock edge
//   branch_target  in   [31:0] redirect byte address
//   imem_req       out  fetch request (from state/pc only)
//   imem_addr      out  [31:0] fetch byte address
//   imem_rdata     in   [31:0] memory word, valid the cycle after a request
//   if_instr       out  [31:0] IF/ID instruction
//   if_pc          out  [31:0] address of if_instr
//   if_nextpc      out  [31:0] if_pc + 4
//   if_valid       out  IF/ID holds a real instruction
//   halted         out  fetch permanently stopped
// ---------------------------------------------------------------------------
module if_fetch_sequencer
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] HALT_ADDR = 32'd48
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_nextpc,
    output logic        if_valid,
    output logic        halted
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic         infl_v;     // a request was sampled at the last edge
    logic [31:0]  infl_tag;   // address of that request
    logic         skid_load;
    logic         skid_clear;
    logic         skid_valid;
    logic [31:0]  skid_word;
    logic [31:0]  skid_pc;
    logic         at_halt;
    logic         redirect;

`ifdef IF_HALT_EN
    localparam bit HALT_EN = 1'b1;
    assign halted = (state == HALTED);
`else
    localparam bit HALT_EN = 1'b0;
    assign halted = 1'b0;
`endif

    assign at_halt   = HALT_EN && (pc == HALT_ADDR);
    assign redirect  = branch_taken && (state != IDLE);
    assign imem_req  = (state == RUN) && !at_halt;
    assign imem_addr = pc;

    // Only the response landing in the first HOLD cycle is parked; the
    // entry is dropped on a redirect or when IF/ID consumes it on release.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no
        // latch is inferred.
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        if (redirect) begin
            skid_clear = 1'b1;
        end else if (state == HOLD) begin
            if (!stall) begin
                skid_clear = 1'b1;
            end else if (infl_v) begin
                skid_load = 1'b1;
            end
        end
    end

    if_skid_buffer u_skid (
        .clk     (clk),
        .reset   (reset),
        .load    (skid_load),
        .clear   (skid_clear),
        .word_in (imem_rdata),
        .pc_in   (infl_tag),
        .valid   (skid_valid),
        .word    (skid_word),
        .pc      (skid_pc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            infl_v    <= 1'b0;
            infl_tag  <= RESET_PC;
            if_instr  <= NOP_WORD;
            if_pc     <= 32'd0;
            if_nextpc <= 32'd0;
            if_valid  <= 1'b0;
        end else if (redirect) begin
            // Redirect kills the request sampled at this edge as well as the
            // one already in flight; IF/ID is invalidated even when stalled.
            pc       <= word_align(branch_target);
            infl_v   <= 1'b0;
            if_valid <= 1'b0;
            if (state == HALTED) begin
                state <= RUN;
            end else if (state == RUN && stall) begin
                state <= HOLD;
            end
        end else begin
            case (state)
                IDLE: begin
                    state <= stall ? HOLD : RUN;
                end

                RUN: begin
                    // The word requested one edge ago is on imem_rdata now.
                    if (infl_v) begin
                        if_instr  <= imem_rdata;
                        if_pc     <= infl_tag;
                        if_nextpc <= infl_tag + PC_STEP;
                        if_valid  <= 1'b1;
                    end else begin
                        if_valid  <= 1'b0;
                    end

                    if (at_halt) begin
                        state  <= HALTED;
                        infl_v <= 1'b0;
                    end else begin
                        // The request is sampled by memory on this edge even
                        // if stall is rising, so the PC must move past it.
                        pc       <= pc + PC_STEP;
                        infl_v   <= 1'b1;
                        infl_tag <= pc;
                        if (stall) begin
                            state <= HOLD;
                        end
                    end
                end

                HOLD: begin
                    infl_v <= 1'b0;
                    if (!stall) begin
                        state <= RUN;
                        if (skid_valid) begin
                            if_instr  <= skid_word;
                            if_pc     <= skid_pc;
                            if_nextpc <= skid_pc + PC_STEP;
                            if_valid  <= 1'b1;
                        end else if (infl_v) begin
                            // One-cycle stall: response goes straight to IF/ID.
                            if_instr  <= imem_rdata;
                            if_pc     <= infl_tag;
                            if_nextpc <= infl_tag + PC_STEP;
                            if_valid  <= 1'b1;
                        end else begin
                            if_valid  <= 1'b0;
                        end
                    end
                end

                HALTED: begin
                    if_valid <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
